// File: rtl/bayer_window_gen.sv
// Bayer 5x5 window generator: raster pixels in, one neighbourhood per
// pixel out, backed by a six-line register ring indexed by row mod 6.
module bayer_window_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 48,
  parameter int PIX_W      = 8,
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PIX_W-1:0]             in_pixel,
  input  logic                         in_sof,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic [0:4][0:4][PIX_W-1:0]   pixel_window,
  output logic [0:4]                   pixel_row_en,
  output logic [0:4]                   pixel_col_en,
  output logic [1:0]                   bayer_center_pixel,
  output logic [XW-1:0]                win_x,
  output logic [YW-1:0]                win_y,
  output logic                         frame_done
);

  localparam logic [XW-1:0] XMAXN = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YMAXN = YW'(IMG_HEIGHT - 1);
  localparam logic [XW+1:0] XLAST = (XW+2)'(IMG_WIDTH - 1);
  localparam logic [YW+1:0] YLAST = (YW+2)'(IMG_HEIGHT - 1);
  localparam logic [XW+1:0] X2    = (XW+2)'(2);
  localparam logic [YW+1:0] Y2    = (YW+2)'(2);
  localparam logic [YW+1:0] Y3    = (YW+2)'(3);

  logic [XW-1:0]    ix, cx;
  logic [YW-1:0]    iy, cy;
  logic [2:0]       iy_slot, cy_slot;
  logic             in_done;
  logic [PIX_W-1:0] lines [0:5][0:IMG_WIDTH-1];

  logic [XW+1:0] ix_e, cx_e, rx;
  logic [YW+1:0] iy_e, cy_e, ry;
  logic          in_fire, win_fire, last_win;
  logic [2:0]    wr_slot;
  logic [XW-1:0] wr_col;

  function automatic logic [2:0] slot_inc(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  assign ix_e = {2'b00, ix};
  assign cx_e = {2'b00, cx};
  assign iy_e = {2'b00, iy};
  assign cy_e = {2'b00, cy};

  // Last input row/column the current window depends on.
  assign rx = (cx_e + X2 > XLAST) ? XLAST : cx_e + X2;
  assign ry = (cy_e + Y2 > YLAST) ? YLAST : cy_e + Y2;

  assign win_valid = in_done || (iy_e > ry) ||
                     ((iy_e == ry) && (ix_e > rx));

  // Row cy+4 would reuse the slot of row cy-2, still in the window.
  assign in_ready = !in_done && (iy_e <= cy_e + Y3);

  assign in_fire  = in_valid && in_ready;
  assign win_fire = win_valid && win_ready;
  assign last_win = (cx == XMAXN) && (cy == YMAXN);

  assign frame_done = win_fire && last_win;

  assign wr_slot = in_sof ? 3'd0 : iy_slot;
  assign wr_col  = in_sof ? '0 : ix;

  logic [0:4]    row_ok, col_ok;
  logic [2:0]    rslot   [0:4];
  logic [XW-1:0] col_idx [0:4];

  for (genvar r = 0; r < 5; r++) begin : g_row
    logic [YW+1:0] ysum;
    logic [3:0]    t;
    assign ysum      = cy_e + (YW+2)'(r);
    assign row_ok[r] = (ysum >= Y2) && (ysum - Y2 <= YLAST);
    assign t         = {1'b0, cy_slot} + 4'(r + 4);
    assign rslot[r]  = (t >= 4'd12) ? 3'(t - 4'd12) :
                       (t >= 4'd6)  ? 3'(t - 4'd6)  : t[2:0];
  end

  for (genvar c = 0; c < 5; c++) begin : g_col
    logic [XW+1:0] xsum, xm2;
    assign xsum       = cx_e + (XW+2)'(c);
    assign xm2        = xsum - X2;
    assign col_ok[c]  = (xsum >= X2) && (xm2 <= XLAST);
    assign col_idx[c] = xm2[XW-1:0];
  end

  for (genvar r = 0; r < 5; r++) begin : g_tr
    for (genvar c = 0; c < 5; c++) begin : g_tc
      assign pixel_window[r][c] =
        (win_valid && row_ok[r] && col_ok[c]) ?
        lines[rslot[r]][col_idx[c]] : '0;
    end
  end

  assign pixel_row_en       = win_valid ? row_ok : 5'b00000;
  assign pixel_col_en       = win_valid ? col_ok : 5'b00000;
  assign bayer_center_pixel = win_valid ? {cy[0], cx[0]} : 2'b00;
  assign win_x              = cx;
  assign win_y              = cy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ix      <= '0;
      iy      <= '0;
      iy_slot <= '0;
      cx      <= '0;
      cy      <= '0;
      cy_slot <= '0;
      in_done <= 1'b0;
      for (int s = 0; s < 6; s++)
        for (int x = 0; x < IMG_WIDTH; x++)
          lines[s][x] <= '0;
    end else begin
      if (in_fire)
        lines[wr_slot][wr_col] <= in_pixel;
      if (in_fire && in_sof) begin
        // Restart: this beat is (0,0), pending windows are dropped.
        ix      <= XW'(1);
        iy      <= '0;
        iy_slot <= '0;
        cx      <= '0;
        cy      <= '0;
        cy_slot <= '0;
        in_done <= 1'b0;
      end else begin
        if (in_fire) begin
          if (ix == XMAXN) begin
            ix <= '0;
            if (iy == YMAXN) begin
              iy      <= '0;
              iy_slot <= '0;
              in_done <= 1'b1;
            end else begin
              iy      <= iy + YW'(1);
              iy_slot <= slot_inc(iy_slot);
            end
          end else begin
            ix <= ix + XW'(1);
          end
        end
        if (win_fire) begin
          if (last_win) begin
            ix      <= '0;
            iy      <= '0;
            iy_slot <= '0;
            cx      <= '0;
            cy      <= '0;
            cy_slot <= '0;
            in_done <= 1'b0;
          end else if (cx == XMAXN) begin
            cx      <= '0;
            cy      <= cy + YW'(1);
            cy_slot <= slot_inc(cy_slot);
          end else begin
            cx <= cx + XW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bayer_window_gen.sv
// Directed and table-driven bench for bayer_window_gen on an 8x6 image,
// with a frame-image reference model for every accepted window.
module tb_bayer_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [7:0]            in_pixel = '0;
  logic                  in_sof = 1'b0;
  logic                  win_valid;
  logic                  win_ready = 1'b0;
  logic [0:4][0:4][7:0]  pixel_window;
  logic [0:4]            pixel_row_en;
  logic [0:4]            pixel_col_en;
  logic [1:0]            bayer_center_pixel;
  logic [2:0]            win_x;
  logic [2:0]            win_y;
  logic                  frame_done;

  bayer_window_gen #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_sof(in_sof),
    .win_valid(win_valid), .win_ready(win_ready),
    .pixel_window(pixel_window),
    .pixel_row_en(pixel_row_en),
    .pixel_col_en(pixel_col_en),
    .bayer_center_pixel(bayer_center_pixel),
    .win_x(win_x), .win_y(win_y),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         mode;
    int         cx;
    int         cy;
    int         r;
    int         c;
    int         pix;
    logic [0:4] row;
    logic [0:4] col;
    int         bay;
  } vec_t;

  vec_t tbl [0:10];

  logic [0:4][0:4][7:0] cap_pix [0:H-1][0:W-1];
  logic [0:4]           cap_row [0:H-1][0:W-1];
  logic [0:4]           cap_col [0:H-1][0:W-1];
  logic [1:0]           cap_bay [0:H-1][0:W-1];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pix(input int mode, input int f,
                             input int y, input int x);
    if (mode == 0) return 100;
    if (mode == 1) return 16 * y + x;
    return (y * 37 + x * 11 + f * 53 + 7) % 256;
  endfunction

  task automatic check_window(input int mode, input int f,
                              input int ex, input int ey);
    int bad, ga, ge, e, yy, xx;
    logic [0:4] er, ec;
    logic [1:0] eb;
    int ah, eh;
    bad = 0; ga = 0; ge = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        yy = ey + r - 2;
        xx = ex + c - 2;
        er[r] = (yy >= 0 && yy < H);
        ec[c] = (xx >= 0 && xx < W);
        e = (yy >= 0 && yy < H && xx >= 0 && xx < W) ?
            pix(mode, f, yy, xx) : 0;
        if (int'(pixel_window[r][c]) != e) begin
          if (bad == 0) begin
            ga = int'(pixel_window[r][c]);
            ge = e;
          end
          bad++;
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL window_taps (%0d,%0d) f%0d: tap got %0d expected %0d, %0d taps wrong",
               ex, ey, f, ga, ge, bad);
    end
    eb = 2'(((ey % 2) << 1) | (ex % 2));
    ah = int'({pixel_row_en, pixel_col_en, bayer_center_pixel,
               win_x, win_y});
    eh = int'({er, ec, eb, 3'(ex), 3'(ey)});
    check("window_fields", ah, eh);
  endtask

  task automatic run_stream(input int nfr, input int vpct,
                            input int rpct, input int hold,
                            input int sof_beat, input int mode);
    int in_f, in_x, in_y, sent, out_f, ex_x, ex_y;
    int done_cnt, fd_cnt, cyc, acc, pix_since;
    bit wait_first, sof_used, sof_sw, rdy_next, lastw;
    logic [0:4][0:4][7:0] snap;
    in_f = 0; in_x = 0; in_y = 0; sent = 0;
    out_f = 0; ex_x = 0; ex_y = 0;
    done_cnt = 0; fd_cnt = 0; cyc = 0; acc = 0; pix_since = 0;
    wait_first = 1; sof_used = 0; sof_sw = 0; rdy_next = 0;
    snap = '0;
    while ((done_cnt < nfr || rdy_next) && cyc < 5000) begin
      @(negedge clk);
      if (sof_beat >= 0 && !sof_used && acc == sof_beat) begin
        sof_used = 1;
        sof_sw = 1;
        in_f++;
        in_x = 0;
        in_y = 0;
      end
      in_valid  = (sent < nfr) && ($urandom_range(99) < vpct);
      in_pixel  = 8'(pix(mode, in_f, in_y, in_x));
      in_sof    = (in_x == 0 && in_y == 0);
      win_ready = (cyc >= hold) && ($urandom_range(99) < rpct);
      #1;
      if (rdy_next) begin
        check("in_ready_after_frame_done", int'(in_ready), 1);
        rdy_next = 0;
      end
      if (wait_first && win_valid) begin
        wait_first = 0;
        snap = pixel_window;
        if (vpct == 100)
          check("first_window_pixels", pix_since, 19);
      end
      if (hold > 0 && cyc == hold - 1) begin
        check("stall_accepted", acc, 32);
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_win_valid", int'(win_valid), 1);
        check("stall_pos", int'({win_x, win_y}), 0);
        check("stall_window_stable", int'(pixel_window == snap), 1);
      end
      if (frame_done) fd_cnt++;
      if (win_valid && win_ready) begin
        check_window(mode, out_f, ex_x, ex_y);
        cap_pix[ex_y][ex_x] = pixel_window;
        cap_row[ex_y][ex_x] = pixel_row_en;
        cap_col[ex_y][ex_x] = pixel_col_en;
        cap_bay[ex_y][ex_x] = bayer_center_pixel;
        lastw = (ex_x == W - 1 && ex_y == H - 1);
        check("frame_done_pulse", int'(frame_done), int'(lastw));
        if (lastw) begin
          done_cnt++;
          out_f++;
          ex_x = 0;
          ex_y = 0;
          rdy_next = 1;
        end else if (ex_x == W - 1) begin
          ex_x = 0;
          ex_y++;
        end else begin
          ex_x++;
        end
      end
      if (in_valid && in_ready) begin
        acc++;
        pix_since++;
        if (sof_sw) begin
          sof_sw = 0;
          out_f = in_f;
          ex_x = 0;
          ex_y = 0;
          wait_first = 1;
          pix_since = 1;
        end
        if (in_x == W - 1) begin
          in_x = 0;
          if (in_y == H - 1) begin
            in_y = 0;
            in_f++;
            sent++;
          end else begin
            in_y++;
          end
        end else begin
          in_x++;
        end
      end
      cyc++;
    end
    check("frames_completed", done_cnt, nfr);
    check("frame_done_count", fd_cnt, nfr);
    @(negedge clk);
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    win_ready = 1'b0;
  endtask

  task automatic apply_table(input int mode);
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].mode == mode) begin
        check($sformatf("tbl%0d_tap", i),
              int'(cap_pix[tbl[i].cy][tbl[i].cx][tbl[i].r][tbl[i].c]),
              tbl[i].pix);
        check($sformatf("tbl%0d_row_en", i),
              int'(cap_row[tbl[i].cy][tbl[i].cx]), int'(tbl[i].row));
        check($sformatf("tbl%0d_col_en", i),
              int'(cap_col[tbl[i].cy][tbl[i].cx]), int'(tbl[i].col));
        check($sformatf("tbl%0d_bayer", i),
              int'(cap_bay[tbl[i].cy][tbl[i].cx]), tbl[i].bay);
      end
    end
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 0,   5'b00111, 5'b00111, 0};
    tbl[1]  = '{0, 0, 0, 2, 2, 100, 5'b00111, 5'b00111, 0};
    tbl[2]  = '{0, 0, 0, 4, 4, 100, 5'b00111, 5'b00111, 0};
    tbl[3]  = '{0, 0, 0, 1, 3, 0,   5'b00111, 5'b00111, 0};
    tbl[4]  = '{0, 7, 5, 0, 0, 100, 5'b11100, 5'b11100, 3};
    tbl[5]  = '{0, 7, 5, 4, 4, 0,   5'b11100, 5'b11100, 3};
    tbl[6]  = '{1, 3, 2, 0, 0, 1,   5'b11111, 5'b11111, 1};
    tbl[7]  = '{1, 3, 2, 2, 2, 35,  5'b11111, 5'b11111, 1};
    tbl[8]  = '{1, 3, 2, 4, 4, 69,  5'b11111, 5'b11111, 1};
    tbl[9]  = '{1, 0, 3, 2, 2, 48,  5'b11111, 5'b00111, 2};
    tbl[10] = '{1, 0, 3, 0, 0, 0,   5'b11111, 5'b00111, 2};

    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_win_valid", int'(win_valid), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_enables", int'({pixel_row_en, pixel_col_en}), 0);
    check("rst_bayer", int'(bayer_center_pixel), 0);
    check("rst_window_zero", int'(pixel_window == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_stream(1, 100, 100, 0, -1, 0);
    apply_table(0);

    run_stream(1, 100, 100, 0, -1, 1);
    apply_table(1);

    run_stream(1, 100, 100, 200, -1, 1);

    run_stream(1, 100, 100, 0, 19, 2);

    // Fill a few rows with windows pending, then reset asynchronously.
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sof    = (i == 0);
      in_pixel  = 8'(i);
      win_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    check("pending_before_reset", int'(win_valid), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_win_valid", int'(win_valid), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    check("midrst_enables", int'({pixel_row_en, pixel_col_en}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_stream(3, 70, 60, 0, -1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
